// File: rtl/parity_check_rx.sv
// Serial parity-checking receiver: deserializes DATA_WIDTH bits LSB first plus one parity bit,
// flags mismatches and keeps a saturating error count.
module parity_check_rx #(
   parameter int unsigned DATA_WIDTH    = 8,
   parameter bit          ODD_PARITY    = 1'b0,
   parameter int unsigned ERR_CNT_WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     bit_valid,
   input  logic                     bit_in,
   input  logic                     sof,
   input  logic                     err_clr,
   output logic [DATA_WIDTH-1:0]    data_out,
   output logic                     data_valid,
   output logic                     parity_err,
   output logic [ERR_CNT_WIDTH-1:0] err_count,
   output logic                     busy
);

   localparam int unsigned IDX_W = $clog2(DATA_WIDTH);

   localparam logic [1:0] StIdle   = 2'd0;
   localparam logic [1:0] StData   = 2'd1;
   localparam logic [1:0] StParity = 2'd2;

   logic [1:0]               state_q, state_d;
   logic [IDX_W-1:0]         idx_q, idx_d;
   logic [DATA_WIDTH-1:0]    shift_q, shift_d;
   logic [DATA_WIDTH-1:0]    dout_q, dout_d;
   logic                     valid_q, valid_d;
   logic                     perr_q, perr_d;
   logic [ERR_CNT_WIDTH-1:0] cnt_q, cnt_d;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      dout_d  = dout_q;
      valid_d = 1'b0;
      perr_d  = perr_q;
      if (bit_valid) begin
         if (sof) begin
            // sof always starts a fresh frame, abandoning any partial one
            shift_d    = '0;
            shift_d[0] = bit_in;
            idx_d      = IDX_W'(1);
            state_d    = StData;
         end else begin
            case (state_q)
               StData: begin
                  shift_d[idx_q] = bit_in;
                  if (idx_q == IDX_W'(DATA_WIDTH - 1)) begin
                     idx_d   = '0;
                     state_d = StParity;
                  end else begin
                     idx_d = idx_q + IDX_W'(1);
                  end
               end
               StParity: begin
                  dout_d  = shift_q;
                  perr_d  = bit_in ^ (^shift_q) ^ ODD_PARITY;
                  valid_d = 1'b1;
                  idx_d   = '0;
                  state_d = StIdle;
               end
               default: ;
            endcase
         end
      end
   end

   // Count on the cycle the flagged word is presented; clear wins over increment
   always_comb begin
      cnt_d = cnt_q;
      if (err_clr) begin
         cnt_d = '0;
      end else if (valid_q && perr_q && (cnt_q != '1)) begin
         cnt_d = cnt_q + ERR_CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         idx_q   <= '0;
         shift_q <= '0;
         dout_q  <= '0;
         valid_q <= 1'b0;
         perr_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         dout_q  <= dout_d;
         valid_q <= valid_d;
         perr_q  <= perr_d;
         cnt_q   <= cnt_d;
      end
   end

   assign data_out   = dout_q;
   assign data_valid = valid_q;
   assign parity_err = perr_q;
   assign err_count  = cnt_q;
   assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_parity_check_rx.sv
// Bench for parity_check_rx: three instances (even/8-bit count, even/2-bit count, odd parity)
// driven frame-by-frame and compared against a frame-level reference model.
module tb_parity_check_rx;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_s[3], bv_s[3], bi_s[3], sof_s[3], clr_s[3];
   logic [7:0] dout[3];
   logic       dv[3], pe[3], bsy[3];
   logic [7:0] cnt0, cnt2;
   logic [1:0] cnt1;

   int unsigned n_cmp = 0;
   int unsigned n_mis = 0;

   // Reference model state per instance
   int unsigned m_cnt[3];
   bit          m_pend[3];
   logic [7:0]  m_data[3];
   bit          m_perr[3];
   bit          m_busy[3];

   parity_check_rx #(.DATA_WIDTH(8), .ODD_PARITY(1'b0), .ERR_CNT_WIDTH(8)) u0 (
      .clk(clk), .rst(rst_s[0]), .bit_valid(bv_s[0]), .bit_in(bi_s[0]), .sof(sof_s[0]),
      .err_clr(clr_s[0]), .data_out(dout[0]), .data_valid(dv[0]), .parity_err(pe[0]),
      .err_count(cnt0), .busy(bsy[0])
   );
   parity_check_rx #(.DATA_WIDTH(8), .ODD_PARITY(1'b0), .ERR_CNT_WIDTH(2)) u1 (
      .clk(clk), .rst(rst_s[1]), .bit_valid(bv_s[1]), .bit_in(bi_s[1]), .sof(sof_s[1]),
      .err_clr(clr_s[1]), .data_out(dout[1]), .data_valid(dv[1]), .parity_err(pe[1]),
      .err_count(cnt1), .busy(bsy[1])
   );
   parity_check_rx #(.DATA_WIDTH(8), .ODD_PARITY(1'b1), .ERR_CNT_WIDTH(8)) u2 (
      .clk(clk), .rst(rst_s[2]), .bit_valid(bv_s[2]), .bit_in(bi_s[2]), .sof(sof_s[2]),
      .err_clr(clr_s[2]), .data_out(dout[2]), .data_valid(dv[2]), .parity_err(pe[2]),
      .err_count(cnt2), .busy(bsy[2])
   );

   function automatic logic [31:0] get_cnt(int k);
      case (k)
         0:       return {24'b0, cnt0};
         1:       return {30'b0, cnt1};
         default: return {24'b0, cnt2};
      endcase
   endfunction

   function automatic int unsigned cnt_max(int k);
      return (k == 1) ? 3 : 255;
   endfunction

   function automatic bit odd(int k);
      return (k == 2);
   endfunction

   task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_all(int k, bit dv_exp);
      check_eq($sformatf("u%0d.data_valid", k), 32'(dv[k]), 32'(dv_exp));
      check_eq($sformatf("u%0d.data_out", k), 32'(dout[k]), 32'(m_data[k]));
      check_eq($sformatf("u%0d.parity_err", k), 32'(pe[k]), 32'(m_perr[k]));
      check_eq($sformatf("u%0d.err_count", k), get_cnt(k), 32'(m_cnt[k]));
      check_eq($sformatf("u%0d.busy", k), 32'(bsy[k]), 32'(m_busy[k]));
   endtask

   // One clock: drive inputs, let the edge happen, advance the model, compare.
   task automatic step(int k, bit v, bit b, bit s, bit c, bit fin, logic [7:0] d, bit pe_exp,
                       bit busy_exp);
      bv_s[k]  = v;
      bi_s[k]  = b;
      sof_s[k] = s;
      clr_s[k] = c;
      @(posedge clk);
      #1;
      bv_s[k]  = 1'b0;
      sof_s[k] = 1'b0;
      clr_s[k] = 1'b0;
      if (c) m_cnt[k] = 0;
      else if (m_pend[k] && m_cnt[k] < cnt_max(k)) m_cnt[k]++;
      m_pend[k] = fin && pe_exp;
      if (fin) begin
         m_data[k] = d;
         m_perr[k] = pe_exp;
      end
      m_busy[k] = busy_exp;
      check_all(k, fin);
   endtask

   task automatic gaps(int k, int mn, int mx);
      int n;
      n = $urandom_range(mx, mn);
      repeat (n) step(k, 1'b0, 1'($urandom()), 1'($urandom()), 1'b0, 1'b0, 8'h00, 1'b0, m_busy[k]);
   endtask

   task automatic send_bits(int k, logic [7:0] d, int n, int mn, int mx);
      for (int i = 0; i < n; i++) begin
         gaps(k, mn, mx);
         step(k, 1'b1, d[i], (i == 0), 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      end
   endtask

   task automatic send_frame(int k, logic [7:0] d, bit p, int mn, int mx);
      bit expected;
      send_bits(k, d, 8, mn, mx);
      gaps(k, mn, mx);
      expected = (^d) ^ odd(k);
      step(k, 1'b1, p, 1'b0, 1'b0, 1'b1, d, (p != expected), 1'b0);
   endtask

   task automatic stray(int k, int n);
      repeat (n) step(k, 1'b1, 1'($urandom()), 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
   endtask

   task automatic idle(int k, int n);
      repeat (n) step(k, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, m_busy[k]);
   endtask

   // Reset is driven together with a sof bit to show reset takes priority.
   task automatic reset_inst(int k);
      rst_s[k] = 1'b1;
      bv_s[k]  = 1'b1;
      sof_s[k] = 1'b1;
      bi_s[k]  = 1'b1;
      @(posedge clk);
      #1;
      rst_s[k] = 1'b0;
      bv_s[k]  = 1'b0;
      sof_s[k] = 1'b0;
      m_cnt[k]  = 0;
      m_pend[k] = 1'b0;
      m_data[k] = 8'h00;
      m_perr[k] = 1'b0;
      m_busy[k] = 1'b0;
      check_all(k, 1'b0);
   endtask

   initial begin
      logic [7:0] d;
      bit         p;
      int         r;
      for (int k = 0; k < 3; k++) begin
         rst_s[k] = 1'b1;
         bv_s[k]  = 1'b0;
         bi_s[k]  = 1'b0;
         sof_s[k] = 1'b0;
         clr_s[k] = 1'b0;
         m_cnt[k] = 0;
         m_pend[k] = 1'b0;
         m_data[k] = 8'h00;
         m_perr[k] = 1'b0;
         m_busy[k] = 1'b0;
      end
      repeat (2) @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
         rst_s[k] = 1'b0;
         check_all(k, 1'b0);
      end

      // Back-to-back good frames, even parity
      send_frame(0, 8'h00, 1'b0, 0, 0);
      send_frame(0, 8'h01, 1'b1, 0, 0);
      send_frame(0, 8'hAA, 1'b0, 0, 0);
      send_frame(0, 8'hFF, 1'b0, 0, 0);
      idle(0, 2);
      // Error detection
      send_frame(0, 8'h03, 1'b1, 0, 0);
      send_frame(0, 8'h03, 1'b0, 0, 0);
      idle(0, 2);
      // Stray bits then a gapped frame
      stray(0, 5);
      send_frame(0, 8'h5A, 1'b0, 1, 1);
      idle(0, 2);
      // Re-sync mid-frame, then reset mid-frame
      send_bits(0, 8'h0F, 4, 0, 0);
      send_frame(0, 8'h81, 1'b0, 0, 0);
      idle(0, 1);
      send_bits(0, 8'h6C, 3, 0, 0);
      reset_inst(0);
      stray(0, 3);
      send_frame(0, 8'h3C, 1'b0, 0, 1);
      idle(0, 1);

      // Saturation with a 2-bit counter, then clear coinciding with an increment
      for (int i = 0; i < 5; i++) send_frame(1, 8'h00, 1'b1, 0, 0);
      idle(1, 1);
      send_frame(1, 8'h00, 1'b1, 0, 0);
      step(1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      idle(1, 1);

      // Odd parity instance
      send_frame(2, 8'h00, 1'b1, 0, 0);
      send_frame(2, 8'h07, 1'b1, 0, 0);
      idle(2, 2);

      // Randomized traffic with gaps, re-syncs, clears and resets
      for (int k = 0; k < 3; k++) begin
         for (int it = 0; it < 40; it++) begin
            r = $urandom_range(9, 0);
            d = 8'($urandom());
            if (r == 9) begin
               reset_inst(k);
            end else if (r == 8 && !m_busy[k]) begin
               stray(k, $urandom_range(3, 1));
            end else if (r == 7) begin
               send_bits(k, d, $urandom_range(8, 1), 0, 2);
            end else if (r == 6) begin
               step(k, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, m_busy[k]);
            end else begin
               p = (^d) ^ odd(k);
               if ($urandom_range(3, 0) == 0) p = ~p;
               send_frame(k, d, p, 0, 2);
            end
         end
         idle(k, 2);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/parity_check_rx.md
Name: parity_check_rx

Overview:
Serial receive-side counterpart of the team's combinational parity generator. Deserializes a frame of DATA_WIDTH data bits (LSB first) followed by one parity bit. Recomputes parity over the received data, presents the word with a one-cycle valid strobe and an error flag, and keeps a saturating error count. Sits between a bit-level link front end and word-level consumer logic.

Parameters:
DATA_WIDTH, 8, number of data bits per frame (>=2).
ODD_PARITY, 0, 0: expected parity bit = XOR of data bits (even parity, same rule as the generator); 1: expected parity bit = inverted XOR.
ERR_CNT_WIDTH, 8, width of the saturating parity-error counter.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous, active-high reset.
bit_valid  input  1  bit_in is sampled this cycle.
bit_in  input  1  serial data/parity bit.
sof  input  1  start of frame; qualified by bit_valid; marks the current bit as data bit 0.
err_clr  input  1  synchronous clear of err_count.
data_out  output  DATA_WIDTH  last completed frame's data word.
data_valid  output  1  one-cycle pulse, frame complete.
parity_err  output  1  parity mismatch for the frame flagged by data_valid; held with data_out.
err_count  output  ERR_CNT_WIDTH  saturating count of frames with parity_err.
busy  output  1  high while a frame is in progress (state != IDLE).

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, bit index=0, shift register=0, data_out=0, data_valid=0, parity_err=0, err_count=0, busy=0. Reset has priority over all inputs. A partial frame is discarded and produces no data_valid.
- States: IDLE, DATA, PARITY.
- IDLE: a bit with bit_valid=1 and sof=0 is ignored. With bit_valid=1 and sof=1, store the bit as data bit 0, set index=1, and go to DATA. If DATA_WIDTH bits are now complete, go to PARITY.
- DATA: each bit_valid cycle stores bit_in at the current index and increments the index. After bit DATA_WIDTH-1 is stored, go to PARITY. Cycles with bit_valid=0 hold all state, so gaps are allowed.
- PARITY: the next bit_valid cycle samples the parity bit. expected = XOR(data) XOR ODD_PARITY. On the following edge:
  - data_out <= received word.
  - parity_err <= (bit_in != expected).
  - data_valid=1 for exactly one cycle.
  - go to IDLE.
- Latency: data_valid is high in the cycle after the parity bit is sampled.
- sof re-sync: sof=1 with bit_valid=1 while in DATA or PARITY abandons the current frame with no data_valid and no count. That bit becomes data bit 0 of a new frame, and the state machine behaves as if it were entered from IDLE.
- Back-to-back frames: a sof bit is accepted in the same cycle data_valid is high, so there are no dead cycles.
- data_out and parity_err keep their values until the next data_valid, or until reset.
- err_count:
  - increments by 1 on each data_valid with parity_err=1.
  - saturates at 2^ERR_CNT_WIDTH-1 and never wraps.
  - err_clr=1 clears it to 0. If err_clr coincides with an error increment, the result is 0 (clear wins).
- busy = 1 in DATA and PARITY, 0 in IDLE.

Test Plan:
- Even parity (ODD_PARITY=0), back-to-back frames: 0x00/p0, 0x01/p1, 0xAA/p0, 0xFF/p0 -> four data_valid pulses with data_out 0x00, 0x01, 0xAA, 0xFF, parity_err=0 each, err_count=0.
- Error detection: frame 0x03 with p=1 -> data_valid, data_out=0x03, parity_err=1, err_count=1. Then 0x03 with p=0 -> parity_err=0, err_count stays 1.
- Gaps and stray bits: 5 bit_valid bits with sof=0 in IDLE, then frame 0x5A/p0 with bit_valid low on every other cycle -> exactly one data_valid, data_out=0x5A, parity_err=0, and no output for the stray bits.
- Re-sync and reset mid-frame:
  - sof after 4 bits of 0x0F, then a full frame 0x81/p0 -> single data_valid with 0x81, err_count unchanged.
  - rst after 3 bits -> all outputs 0, and no data_valid until the next complete frame.
- Counter rules (ERR_CNT_WIDTH=2): 5 consecutive bad-parity frames -> err_count 1, 2, 3, 3, 3. Then err_clr asserted in the same cycle as a 6th error -> err_count=0.
- ODD_PARITY=1 instance: 0x00/p1 -> parity_err=0; 0x07/p1 -> parity_err=1, err_count=1.
